// File: rtl/hsem_irq_responder_pkg.sv
// Shared constants and types for the HSEM interrupt responder.
// Register map, AHB encodings and FSM state types.
package hsem_irq_responder_pkg;

    localparam int HSEM_DATA_WIDTH = 32;
    localparam int HSEM_ADDR_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [31:0] HSEM_INTR_REG_ADDR  = 32'h0000_0010;
    localparam logic [31:0] HSEM_INTR_CLR_ADDR  = 32'h0000_0014;
    localparam logic [31:0] HSEM_ERR_REG_ADDR   = 32'h0000_0018;
    localparam logic [31:0] HSEM_ERR_CLR_ADDR   = 32'h0000_001C;
    localparam logic [31:0] HSEM_ERROR_PRODUCED = 32'h0000_00EE;

    typedef enum logic [1:0] {
        M_IDLE,
        M_ADDR,
        M_DATA
    } bus_phase_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_INT_A,
        S_RD_INT_D,
        S_RD_ERR_A,
        S_RD_ERR_D,
        S_WR_ECLR_A,
        S_WR_ECLR_D,
        S_WR_ICLR_A,
        S_WR_ICLR_D,
        S_REPORT,
        S_HOLDOFF
    } svc_state_t;

endpackage

// File: rtl/hsem_ahb_single_master.sv
// Single-transfer, non-pipelined AHB-lite master.
// Handles address/data phases, hresp and wait-state timeout.
module hsem_ahb_single_master
    import hsem_irq_responder_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [DW-1:0] hwdata,
    input  logic [DW-1:0] hrdata,
    input  logic          hready,
    input  logic          hresp
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    bus_phase_t    phase;
    logic [7:0]    wait_cnt;
    logic [DW-1:0] wdata_q;
    logic          tmo;
    logic          data_ok;

    // Last tolerated low-hready cycle of a phase aborts the transfer
    assign tmo = (phase != M_IDLE) && !hready && (wait_cnt == TMO_LAST);
    assign data_ok = (phase == M_DATA) && hready;
    assign done  = data_ok || tmo;
    assign err   = (data_ok && hresp) || tmo;
    assign rdata = hrdata;
    assign hsize = HSIZE_WORD;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            phase    <= M_IDLE;
            wait_cnt <= '0;
            htrans   <= HTRANS_IDLE;
            hwrite   <= 1'b0;
            haddr    <= '0;
            hwdata   <= '0;
            wdata_q  <= '0;
        end else begin
            unique case (phase)
                M_IDLE: begin
                    if (req) begin
                        phase    <= M_ADDR;
                        htrans   <= HTRANS_NONSEQ;
                        haddr    <= addr;
                        hwrite   <= we;
                        wdata_q  <= wdata;
                        wait_cnt <= '0;
                    end
                end
                M_ADDR: begin
                    if (tmo) begin
                        phase  <= M_IDLE;
                        htrans <= HTRANS_IDLE;
                    end else if (hready) begin
                        phase    <= M_DATA;
                        htrans   <= HTRANS_IDLE;
                        hwdata   <= hwrite ? wdata_q : '0;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                M_DATA: begin
                    if (done) begin
                        phase  <= M_IDLE;
                        hwdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: phase <= M_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hsem_irq_responder.sv
// Core-side HSEM interrupt service engine: reads/clears the
// interrupt and error registers, then reports via valid/ready.
module hsem_irq_responder
    import hsem_irq_responder_pkg::*;
#(
    parameter int AHB_DATA_WIDTH = HSEM_DATA_WIDTH,
    parameter int AHB_ADDR_WIDTH = HSEM_ADDR_WIDTH,
    parameter logic [AHB_ADDR_WIDTH-1:0] INTR_REG_ADDR =
        AHB_ADDR_WIDTH'(HSEM_INTR_REG_ADDR),
    parameter logic [AHB_ADDR_WIDTH-1:0] INTR_CLR_ADDR =
        AHB_ADDR_WIDTH'(HSEM_INTR_CLR_ADDR),
    parameter logic [AHB_ADDR_WIDTH-1:0] ERR_REG_ADDR =
        AHB_ADDR_WIDTH'(HSEM_ERR_REG_ADDR),
    parameter logic [AHB_ADDR_WIDTH-1:0] ERR_CLR_ADDR =
        AHB_ADDR_WIDTH'(HSEM_ERR_CLR_ADDR),
    parameter logic [AHB_DATA_WIDTH-1:0] ERROR_PRODUCED =
        AHB_DATA_WIDTH'(HSEM_ERROR_PRODUCED),
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      intr,
    output logic [AHB_ADDR_WIDTH-1:0] haddr,
    output logic [1:0]                htrans,
    output logic                      hwrite,
    output logic [2:0]                hsize,
    output logic [AHB_DATA_WIDTH-1:0] hwdata,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata,
    input  logic                      hready,
    input  logic                      hresp,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [AHB_DATA_WIDTH-1:0] evt_intr_code,
    output logic [AHB_DATA_WIDTH-1:0] evt_err_code,
    output logic                      evt_bus_err,
    output logic                      busy
);

    svc_state_t state, state_nxt;

    logic                      req;
    logic                      we;
    logic [AHB_ADDR_WIDTH-1:0] addr;
    logic                      done;
    logic                      err;
    logic [AHB_DATA_WIDTH-1:0] rdata;

    hsem_ahb_single_master #(
        .DW          (AHB_DATA_WIDTH),
        .AW          (AHB_ADDR_WIDTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_master (
        .hclk   (hclk),
        .hreset (hreset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  ('0),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .haddr  (haddr),
        .htrans (htrans),
        .hwrite (hwrite),
        .hsize  (hsize),
        .hwdata (hwdata),
        .hrdata (hrdata),
        .hready (hready),
        .hresp  (hresp)
    );

    assign evt_valid = (state == S_REPORT);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        we        = 1'b0;
        addr      = '0;
        unique case (state)
            S_IDLE: if (intr) state_nxt = S_RD_INT_A;
            S_RD_INT_A: begin
                req       = 1'b1;
                addr      = INTR_REG_ADDR;
                state_nxt = S_RD_INT_D;
            end
            S_RD_INT_D: begin
                if (done) begin
                    if (err)                    state_nxt = S_REPORT;
                    else if (rdata == '0)       state_nxt = S_HOLDOFF;
                    else if (rdata == ERROR_PRODUCED)
                                                state_nxt = S_RD_ERR_A;
                    else                        state_nxt = S_WR_ICLR_A;
                end
            end
            S_RD_ERR_A: begin
                req       = 1'b1;
                addr      = ERR_REG_ADDR;
                state_nxt = S_RD_ERR_D;
            end
            S_RD_ERR_D:
                if (done) state_nxt = err ? S_REPORT : S_WR_ECLR_A;
            S_WR_ECLR_A: begin
                req       = 1'b1;
                we        = 1'b1;
                addr      = ERR_CLR_ADDR;
                state_nxt = S_WR_ECLR_D;
            end
            S_WR_ECLR_D:
                if (done) state_nxt = err ? S_REPORT : S_WR_ICLR_A;
            S_WR_ICLR_A: begin
                req       = 1'b1;
                we        = 1'b1;
                addr      = INTR_CLR_ADDR;
                state_nxt = S_WR_ICLR_D;
            end
            S_WR_ICLR_D: if (done) state_nxt = S_REPORT;
            S_REPORT:    if (evt_ready) state_nxt = S_HOLDOFF;
            S_HOLDOFF:   state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Read data is only trusted when the transfer ended without error
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            evt_intr_code <= '0;
            evt_err_code  <= '0;
            evt_bus_err   <= 1'b0;
        end else begin
            if (state == S_IDLE && intr) begin
                evt_err_code <= '0;
                evt_bus_err  <= 1'b0;
            end
            if (done && err) evt_bus_err <= 1'b1;
            if (state == S_RD_INT_D && done && !err)
                evt_intr_code <= rdata;
            if (state == S_RD_ERR_D && done && !err)
                evt_err_code <= rdata;
        end
    end

endmodule

// File: tb/tb_hsem_irq_responder.sv
// Directed bench for hsem_irq_responder with a simple AHB slave
// that logs every completed transfer.
module tb_hsem_irq_responder;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        intr = 1'b0;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [31:0] evt_intr_code;
    logic [31:0] evt_err_code;
    logic        evt_bus_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int          ws = 0;
    bit          stuck = 0;
    logic [31:0] int_val = 32'h0;
    logic [31:0] err_val = 32'h0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] log_addr [64];
    bit          log_wr [64];
    logic [31:0] log_wdata [64];
    int          log_cnt = 0;
    bit          unstable = 0;

    always #5 hclk = ~hclk;

    hsem_irq_responder dut (
        .hclk          (hclk),
        .hreset        (hreset),
        .intr          (intr),
        .haddr         (haddr),
        .htrans        (htrans),
        .hwrite        (hwrite),
        .hsize         (hsize),
        .hwdata        (hwdata),
        .hrdata        (hrdata),
        .hready        (hready),
        .hresp         (hresp),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_intr_code (evt_intr_code),
        .evt_err_code  (evt_err_code),
        .evt_bus_err   (evt_bus_err),
        .busy          (busy)
    );

    // Slave: decides hready/hrdata/hresp just after each clock edge
    initial begin : slave
        int          wcnt;
        bit          pend;
        bit          w;
        logic [31:0] a;
        logic [31:0] a0;
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = 32'h0;
        wcnt   = 0;
        pend   = 0;
        w      = 0;
        a      = 32'h0;
        a0     = 32'h0;
        forever begin
            @(posedge hclk);
            #1;
            hresp = 1'b0;
            if (hreset) begin
                pend   = 0;
                wcnt   = 0;
                hready = 1'b1;
            end else if (stuck) begin
                hready = 1'b0;
            end else if (htrans == 2'b10) begin
                if (wcnt == 0) a0 = haddr;
                else if (haddr !== a0) unstable = 1;
                if (wcnt < ws) begin
                    hready = 1'b0;
                    wcnt++;
                end else begin
                    hready = 1'b1;
                    wcnt = 0;
                    a = haddr;
                    w = hwrite;
                    pend = 1;
                end
            end else if (pend) begin
                if (wcnt < ws) begin
                    hready = 1'b0;
                    wcnt++;
                end else begin
                    hready = 1'b1;
                    wcnt = 0;
                    pend = 0;
                    hrdata = (a == 32'h10) ? int_val :
                             (a == 32'h18) ? err_val : 32'h0;
                    hresp = (a == err_addr);
                    if (log_cnt < 64) begin
                        log_addr[log_cnt]  = a;
                        log_wr[log_cnt]    = w;
                        log_wdata[log_cnt] = hwdata;
                    end
                    log_cnt++;
                end
            end else begin
                hready = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(negedge hclk);
        hreset    = 1'b1;
        intr      = 1'b0;
        evt_ready = 1'b0;
        ws        = 0;
        stuck     = 0;
        err_addr  = 32'hFFFF_FFFF;
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        int i;
        i  = 0;
        ok = 0;
        while (!ok && i < lim) begin
            @(negedge hclk);
            ok = evt_valid;
            i++;
        end
    endtask

    task automatic handshake();
        @(negedge hclk);
        evt_ready = 1'b1;
        @(negedge hclk);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({htrans, hwrite, haddr, hwdata} !== 67'h0) begin
            errors++;
            $display("FAIL reset_bus got htrans=%b hwrite=%b haddr=%h hwdata=%h exp all 0",
                     htrans, hwrite, haddr, hwdata);
        end
        checks++;
        if ({evt_valid, evt_intr_code, evt_err_code, evt_bus_err, busy} !== 67'h0) begin
            errors++;
            $display("FAIL reset_evt got v=%b ic=%h ec=%h be=%b busy=%b exp all 0",
                     evt_valid, evt_intr_code, evt_err_code, evt_bus_err, busy);
        end
        checks++;
        if (hsize !== 3'b010) begin
            errors++;
            $display("FAIL reset_hsize got %b exp 010", hsize);
        end
    endtask

    task automatic test_normal();
        bit ok;
        int b;
        do_reset();
        b = log_cnt;
        int_val = 32'h3;
        intr = 1'b1;
        wait_valid(50, ok);
        intr = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL normal_valid got timeout exp evt_valid");
        end
        checks++;
        if ({evt_intr_code, evt_err_code, evt_bus_err} !== {32'h3, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL normal_codes got ic=%h ec=%h be=%b exp 3 0 0",
                     evt_intr_code, evt_err_code, evt_bus_err);
        end
        checks++;
        if (log_cnt - b != 2) begin
            errors++;
            $display("FAIL normal_count got %0d exp 2", log_cnt - b);
        end
        checks++;
        if ({log_addr[b], log_wr[b]} !== {32'h10, 1'b0}) begin
            errors++;
            $display("FAIL normal_xfer0 got %h/%b exp 10/0", log_addr[b], log_wr[b]);
        end
        checks++;
        if ({log_addr[b+1], log_wr[b+1], log_wdata[b+1]} !== {32'h14, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL normal_xfer1 got %h/%b/%h exp 14/1/0",
                     log_addr[b+1], log_wr[b+1], log_wdata[b+1]);
        end
        repeat (3) @(negedge hclk);
        checks++;
        if ({evt_valid, evt_intr_code} !== {1'b1, 32'h3}) begin
            errors++;
            $display("FAIL normal_hold got v=%b ic=%h exp 1 3", evt_valid, evt_intr_code);
        end
        evt_ready = 1'b1;
        @(negedge hclk);
        evt_ready = 1'b0;
        checks++;
        if ({evt_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL normal_holdoff got v=%b busy=%b exp 0 1", evt_valid, busy);
        end
        @(negedge hclk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL normal_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_error_path(input int wsv);
        bit          ok;
        int          b;
        logic [31:0] ea [4];
        bit          ew [4];
        ea[0] = 32'h10; ew[0] = 0;
        ea[1] = 32'h18; ew[1] = 0;
        ea[2] = 32'h1C; ew[2] = 1;
        ea[3] = 32'h14; ew[3] = 1;
        do_reset();
        ws = wsv;
        b = log_cnt;
        int_val = 32'hEE;
        err_val = 32'h5;
        intr = 1'b1;
        wait_valid(300, ok);
        intr = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL err%0d_valid got timeout exp evt_valid", wsv);
        end
        checks++;
        if ({evt_intr_code, evt_err_code, evt_bus_err} !== {32'hEE, 32'h5, 1'b0}) begin
            errors++;
            $display("FAIL err%0d_codes got ic=%h ec=%h be=%b exp EE 5 0",
                     wsv, evt_intr_code, evt_err_code, evt_bus_err);
        end
        checks++;
        if (log_cnt - b != 4) begin
            errors++;
            $display("FAIL err%0d_count got %0d exp 4", wsv, log_cnt - b);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({log_addr[b+i], log_wr[b+i]} !== {ea[i], ew[i]}) begin
                errors++;
                $display("FAIL err%0d_xfer%0d got %h/%b exp %h/%b",
                         wsv, i, log_addr[b+i], log_wr[b+i], ea[i], ew[i]);
            end
        end
        checks++;
        if (unstable !== 1'b0) begin
            errors++;
            $display("FAIL err%0d_addr_stable got unstable=%b exp 0", wsv, unstable);
        end
        handshake();
    endtask

    task automatic test_bus_error();
        bit ok;
        int b;
        do_reset();
        b = log_cnt;
        err_addr = 32'h18;
        int_val = 32'hEE;
        err_val = 32'h5;
        intr = 1'b1;
        wait_valid(50, ok);
        intr = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL buserr_valid got timeout exp evt_valid");
        end
        checks++;
        if ({evt_intr_code, evt_err_code, evt_bus_err} !== {32'hEE, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL buserr_codes got ic=%h ec=%h be=%b exp EE 0 1",
                     evt_intr_code, evt_err_code, evt_bus_err);
        end
        checks++;
        if (log_cnt - b != 2 || log_addr[b+1] !== 32'h18) begin
            errors++;
            $display("FAIL buserr_xfers got n=%0d last=%h exp 2 18",
                     log_cnt - b, log_addr[b+1]);
        end
        handshake();
        repeat (2) @(negedge hclk);
        err_addr = 32'hFFFF_FFFF;
        int_val = 32'h7;
        intr = 1'b1;
        wait_valid(50, ok);
        intr = 1'b0;
        checks++;
        if (!ok || {evt_intr_code, evt_bus_err} !== {32'h7, 1'b0}) begin
            errors++;
            $display("FAIL buserr_cleared got ok=%b ic=%h be=%b exp 1 7 0",
                     ok, evt_intr_code, evt_bus_err);
        end
        handshake();
    endtask

    task automatic test_timeout();
        int b;
        int n;
        int i;
        do_reset();
        b = log_cnt;
        stuck = 1;
        int_val = 32'h3;
        intr = 1'b1;
        i = 0;
        while (htrans !== 2'b10 && i < 20) begin
            @(negedge hclk);
            i++;
        end
        n = 0;
        while (evt_valid !== 1'b1 && n < 400) begin
            @(negedge hclk);
            n++;
        end
        stuck = 0;
        intr = 1'b0;
        checks++;
        if (n != 255) begin
            errors++;
            $display("FAIL timeout_cycles got %0d exp 255", n);
        end
        checks++;
        if ({evt_valid, evt_bus_err, htrans} !== {1'b1, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL timeout_abort got v=%b be=%b htrans=%b exp 1 1 00",
                     evt_valid, evt_bus_err, htrans);
        end
        checks++;
        if (log_cnt != b) begin
            errors++;
            $display("FAIL timeout_xfers got %0d exp 0", log_cnt - b);
        end
        handshake();
    endtask

    task automatic test_spurious_holdoff();
        bit ok;
        int b;
        int i;
        do_reset();
        b = log_cnt;
        int_val = 32'h0;
        intr = 1'b1;
        i = 0;
        while (log_cnt - b < 1 && i < 50) begin
            @(negedge hclk);
            i++;
        end
        @(negedge hclk);
        checks++;
        if ({busy, evt_valid, evt_intr_code} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL spur_holdoff got busy=%b v=%b ic=%h exp 1 0 0",
                     busy, evt_valid, evt_intr_code);
        end
        @(negedge hclk);
        checks++;
        if ({busy, evt_valid} !== 2'b00) begin
            errors++;
            $display("FAIL spur_idle got busy=%b v=%b exp 0 0", busy, evt_valid);
        end
        @(negedge hclk);
        checks++;
        if ({busy, htrans} !== {1'b1, 2'b00}) begin
            errors++;
            $display("FAIL spur_restart got busy=%b htrans=%b exp 1 00", busy, htrans);
        end
        @(negedge hclk);
        checks++;
        if ({htrans, haddr, hwrite} !== {2'b10, 32'h10, 1'b0}) begin
            errors++;
            $display("FAIL spur_second got htrans=%b haddr=%h hw=%b exp 10 10 0",
                     htrans, haddr, hwrite);
        end
        checks++;
        if (log_cnt - b != 1) begin
            errors++;
            $display("FAIL spur_noclear got %0d exp 1", log_cnt - b);
        end
        int_val = 32'h3;
        wait_valid(50, ok);
        intr = 1'b0;
        checks++;
        if (!ok || evt_intr_code !== 32'h3 || log_cnt - b != 3) begin
            errors++;
            $display("FAIL spur_seq2 got ok=%b ic=%h n=%0d exp 1 3 3",
                     ok, evt_intr_code, log_cnt - b);
        end
        handshake();
    endtask

    task automatic test_ready_early();
        int b;
        int nv;
        logic [31:0] ic;
        do_reset();
        b = log_cnt;
        evt_ready = 1'b1;
        int_val = 32'h5;
        intr = 1'b1;
        nv = 0;
        ic = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge hclk);
            if (evt_valid) begin
                nv++;
                ic = evt_intr_code;
                intr = 1'b0;
            end
        end
        evt_ready = 1'b0;
        checks++;
        if (nv != 1) begin
            errors++;
            $display("FAIL early_valid_cycles got %0d exp 1", nv);
        end
        checks++;
        if (ic !== 32'h5 || log_cnt - b != 2) begin
            errors++;
            $display("FAIL early_seq got ic=%h n=%0d exp 5 2", ic, log_cnt - b);
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        int b;
        int i;
        bit found;
        do_reset();
        ws = 3;
        b = log_cnt;
        int_val = 32'hEE;
        err_val = 32'h5;
        intr = 1'b1;
        i = 0;
        found = 0;
        while (!found && i < 200) begin
            @(negedge hclk);
            found = (log_cnt - b == 2) && htrans == 2'b00 &&
                    hwrite && haddr == 32'h1C;
            i++;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midop_reach got timeout exp ECLR data phase");
        end
        hreset = 1'b1;
        #1;
        checks++;
        if ({htrans, evt_valid, busy, haddr} !== {2'b00, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL midop_reset got htrans=%b v=%b busy=%b haddr=%h exp 00 0 0 0",
                     htrans, evt_valid, busy, haddr);
        end
        @(negedge hclk);
        hreset = 1'b0;
        i = 0;
        while (htrans !== 2'b10 && i < 20) begin
            @(negedge hclk);
            i++;
        end
        checks++;
        if ({htrans, haddr, hwrite} !== {2'b10, 32'h10, 1'b0}) begin
            errors++;
            $display("FAIL midop_restart got htrans=%b haddr=%h hw=%b exp 10 10 0",
                     htrans, haddr, hwrite);
        end
        wait_valid(300, ok);
        intr = 1'b0;
        checks++;
        if (!ok || {evt_intr_code, evt_err_code} !== {32'hEE, 32'h5}) begin
            errors++;
            $display("FAIL midop_complete got ok=%b ic=%h ec=%h exp 1 EE 5",
                     ok, evt_intr_code, evt_err_code);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_error_path(0);
        test_error_path(3);
        test_bus_error();
        test_timeout();
        test_spurious_holdoff();
        test_ready_early();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hsem_irq_responder.md
Name: hsem_irq_responder

Overview:
- Core-side service engine for one HSEM interrupt line: the responder end of the HSEM interrupt/error path.
- On `intr` assertion it acts as a single-transfer AHB-lite master and runs a fixed sequence:
  - reads the core's interrupt register;
  - if the value is the error code, reads the error register and clears it;
  - clears the interrupt register.
- It then presents the captured codes to the core through a valid/ready event port.
- One instance per core, placed between the HSEM interrupt output and the core's local bus.

Parameters:
- AHB_DATA_WIDTH, 32, data bus width
- AHB_ADDR_WIDTH, 32, address bus width
- INTR_REG_ADDR, 32'h0000_0010, interrupt register address for this core
- INTR_CLR_ADDR, 32'h0000_0014, interrupt-clear register address
- ERR_REG_ADDR, 32'h0000_0018, error register address
- ERR_CLR_ADDR, 32'h0000_001C, error-clear register address
- ERROR_PRODUCED, 32'h0000_00EE, interrupt code meaning "error latched"
- TIMEOUT_CYC, 255, maximum hready-low cycles per phase before abort (8-bit counter)

Ports:
- hclk  in  1  clock
- hreset  in  1  reset, asynchronous, active-high
- intr  in  1  level interrupt from HSEM
- haddr  out  AHB_ADDR_WIDTH  address
- htrans  out  2  IDLE=2'b00, NONSEQ=2'b10 only
- hwrite  out  1  1 = write
- hsize  out  3  fixed 3'b010 (word)
- hwdata  out  AHB_DATA_WIDTH  write data; always 0 for clear writes
- hrdata  in  AHB_DATA_WIDTH  read data
- hready  in  1  transfer ready
- hresp  in  1  1 = ERROR
- evt_valid  out  1  event available to core
- evt_ready  in  1  core accepts event
- evt_intr_code  out  AHB_DATA_WIDTH  captured interrupt register value
- evt_err_code  out  AHB_DATA_WIDTH  captured error register value; 0 if not read
- evt_bus_err  out  1  sequence aborted (hresp ERROR or timeout)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, hreset=1):
  - state=IDLE; htrans=IDLE; hwrite=0; haddr=0; hwdata=0.
  - evt_valid=0; evt_intr_code=0; evt_err_code=0; evt_bus_err=0; busy=0; timeout counter=0.
  - Applies immediately, including mid-transfer.
- Transfer protocol: non-pipelined, registered outputs.
  - Address phase: htrans=NONSEQ, haddr/hwrite driven; held until a cycle with hready=1.
  - Data phase: htrans=IDLE; hwdata valid for writes; completes on the first cycle with hready=1.
  - Read data is sampled in the completing data-phase cycle.
- States (A = address phase, D = data phase):
  - IDLE: intr=1 → RD_INT_A.
  - RD_INT_A → RD_INT_D.
  - RD_INT_D: on completion, capture evt_intr_code.
    - Value 0 (spurious) → HOLDOFF.
    - Value == ERROR_PRODUCED → RD_ERR_A.
    - Otherwise → WR_ICLR_A.
  - RD_ERR_A → RD_ERR_D; on completion capture evt_err_code → WR_ECLR_A.
  - WR_ECLR_A/D: write ERR_CLR_ADDR → WR_ICLR_A.
  - WR_ICLR_A/D: write INTR_CLR_ADDR → REPORT.
  - REPORT: evt_valid=1, outputs stable until evt_ready=1; then → HOLDOFF.
  - HOLDOFF: one cycle, intr ignored (HSEM deasserts `intr` one cycle after the clear write) → IDLE.
- Bus error:
  - hresp=1 in any data phase → evt_bus_err=1, then REPORT.
  - Captured codes keep the values read so far; remaining clears are skipped.
- Timeout:
  - The counter resets at every phase entry and increments each cycle hready=0.
  - Reaching TIMEOUT_CYC → treated as a bus error.
  - htrans returns to IDLE on abort.
- evt_valid and evt_ready in the same cycle: the handshake completes; evt_valid drops the next cycle.
- Fields are cleared at RD_INT_A entry: evt_err_code=0, evt_bus_err=0.
- If intr is still high after HOLDOFF (new error raised during service), a new sequence starts from IDLE.
- evt_ready while not in REPORT is ignored.

Decomposition:
- Shared package/defines (extend existing sem_config defines): AHB_DATA_WIDTH, HTRANS encodings, HSIZE_WORD, ERROR_PRODUCED, register offsets.
- One sub-module is natural: hsem_ahb_single_master.
  - Owns the address/data-phase handshake, hresp handling and timeout counter.
  - Interface: req/we/addr/wdata in; done/rdata/err out.
- The top level holds only the service FSM and event registers.

Test Plan:
- Normal interrupt: intr=1, hrdata=32'h0000_0003 on INTR read, hready=1 → reads 0x10, writes 0 to 0x14, no access to 0x18/0x1C; evt_valid with intr_code=3, err_code=0; back in IDLE 2 cycles after evt_ready.
- Error path: INTR read returns 32'hEE, ERR read returns 32'h0000_0005 → bus order 0x10 R, 0x18 R, 0x1C W, 0x14 W; event intr_code=0xEE, err_code=5, bus_err=0.
- Wait states: hready low 3 cycles in each phase → address held stable, same transfer order and codes, no extra transfers.
- Bus error/timeout: hresp=1 on 0x18 read → evt_bus_err=1, no clear writes. hready stuck low 255 cycles → abort, evt_bus_err=1.
- Spurious and holdoff: INTR read returns 0 → no clears, no evt_valid. Then intr held high through HOLDOFF → a second sequence starts exactly one cycle after HOLDOFF.
- Reset mid-op: assert hreset during WR_ECLR data phase → htrans=IDLE, evt_valid=0, busy=0 in the same cycle; after release with intr=1, the sequence restarts at 0x10.
